// File: rtl/cache_tag_assoc_if.sv
// rtl/cache_tag_assoc_if.sv - request/response bundle for the set-associative tag engine
//
// Purpose: groups the request handshake and the lookup response of
// cache_tag_assoc so both sides share one parameterised type.
// Signals:
//   req_valid/req_ready  request handshake (requester -> engine)
//   req_addr [ADDR_W]    address: tag | index | byte offset
//   req_op   [2]         00 lookup, 01 lookup+allocate, 10 invalidate, 11 flush
//   resp_valid           one-cycle response pulse
//   resp_hit             tag matched a valid way before any update
//   resp_way [WAY_W]     hit way, else allocated way, else 0
//   resp_evict           allocation replaced a valid line
//   resp_evict_tag       tag of the replaced line, else 0
// Modports: master = requester, slave = engine.
interface cache_tag_assoc_if #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 6,
  parameter int WAYS     = 2
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_op;
  logic              resp_valid;
  logic              resp_hit;
  logic [WAY_W-1:0]  resp_way;
  logic              resp_evict;
  logic [TAG_W-1:0]  resp_evict_tag;

  modport master (
    output req_valid, req_addr, req_op,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag
  );

  modport slave (
    input  req_valid, req_addr, req_op,
    output req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag
  );
endinterface

// File: rtl/cache_tag_assoc.sv
// rtl/cache_tag_assoc.sv - N-way set-associative tag store and lookup engine
//
// Purpose: holds tags, valid bits and a round-robin pointer per set; serves
// lookup, lookup+allocate, line invalidate and whole-cache flush requests,
// one request per three cycles, with a one-cycle response pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; starts a full flush on release
//   bus    cache_tag_assoc_if.slave (request handshake + response fields)
module cache_tag_assoc #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 6,
  parameter int WAYS     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_tag_assoc_if.slave     bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_ALLOC  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_e;

  // Storage
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_mem_q [SETS][WAYS];
  logic [WAY_W-1:0] ptr_q [SETS];

  // Control state and captured request
  state_e           state_q;
  logic [INDEX_W-1:0] flush_cnt_q;
  logic             flush_resp_q;
  logic [TAG_W-1:0] req_tag_q;
  logic [INDEX_W-1:0] req_idx_q;
  logic [1:0]       req_op_q;

  // Registered outputs
  logic             ready_q;
  logic             resp_valid_q;
  logic             resp_hit_q;
  logic [WAY_W-1:0] resp_way_q;
  logic             resp_evict_q;
  logic [TAG_W-1:0] resp_evict_tag_q;

  // Offset bits never take part in a lookup.
  logic unused_addr;
  assign unused_addr = &{1'b0, bus.req_addr};

  // Tag compare and free-way search over the captured set.
  logic             hit_d;
  logic [WAY_W-1:0] hit_way_d;
  logic             free_d;
  logic [WAY_W-1:0] free_way_d;
  logic [WAY_W-1:0] victim_way_d;
  logic [WAY_W-1:0] ptr_cur;
  logic [WAY_W-1:0] ptr_next;

  always_comb begin
    hit_d      = 1'b0;
    hit_way_d  = '0;
    free_d     = 1'b0;
    free_way_d = '0;
    // Scanning upward and latching the first match makes the lowest way win,
    // both for duplicate hits and for the invalid-first victim choice.
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_d && valid_q[req_idx_q][w] && (tag_mem_q[req_idx_q][w] == req_tag_q)) begin
        hit_d     = 1'b1;
        hit_way_d = WAY_W'(w);
      end
      if (!free_d && !valid_q[req_idx_q][w]) begin
        free_d     = 1'b1;
        free_way_d = WAY_W'(w);
      end
    end
  end

  assign ptr_cur      = ptr_q[req_idx_q];
  assign ptr_next     = (ptr_cur == LAST_WAY) ? '0 : ptr_cur + 1'b1;
  assign victim_way_d = free_d ? free_way_d : ptr_cur;

  // Array updates happen only at the end of RESP (or per set in FLUSH);
  // a reset edge suppresses them so an aborted request leaves no trace.
  logic fill_en;
  logic inval_en;
  assign fill_en  = rst_n && (state_q == S_RESP) && (req_op_q == OP_ALLOC) && !resp_hit_q;
  assign inval_en = rst_n && (state_q == S_RESP) && (req_op_q == OP_INVAL) && resp_hit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else if (state_q == S_FLUSH) begin
      valid_q[flush_cnt_q] <= '0;
      ptr_q[flush_cnt_q]   <= '0;
    end else if (fill_en) begin
      valid_q[req_idx_q][resp_way_q] <= 1'b1;
      // Pointer only advances when a valid line was displaced.
      if (resp_evict_q) begin
        ptr_q[req_idx_q] <= ptr_next;
      end
    end else if (inval_en) begin
      valid_q[req_idx_q][resp_way_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem_q[req_idx_q][resp_way_q] <= req_tag_q;
    end
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_FLUSH;
      flush_cnt_q      <= '0;
      flush_resp_q     <= 1'b0;
      req_tag_q        <= '0;
      req_idx_q        <= '0;
      req_op_q         <= OP_LOOKUP;
      ready_q          <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_way_q       <= '0;
      resp_evict_q     <= 1'b0;
      resp_evict_tag_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          if (flush_cnt_q == '1) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= flush_resp_q;
            flush_resp_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q   <= 1'b0;
            req_tag_q <= bus.req_addr[ADDR_W-1 -: TAG_W];
            req_idx_q <= bus.req_addr[OFFSET_W +: INDEX_W];
            req_op_q  <= bus.req_op;
            if (bus.req_op == OP_FLUSH) begin
              state_q          <= S_FLUSH;
              flush_cnt_q      <= '0;
              flush_resp_q     <= 1'b1;
              resp_hit_q       <= 1'b0;
              resp_way_q       <= '0;
              resp_evict_q     <= 1'b0;
              resp_evict_tag_q <= '0;
            end else begin
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit_d;
          if (hit_d) begin
            resp_way_q <= hit_way_d;
          end else if (req_op_q == OP_ALLOC) begin
            resp_way_q <= victim_way_d;
          end else begin
            resp_way_q <= '0;
          end
          // Eviction only when allocating on a miss into a full set.
          if ((req_op_q == OP_ALLOC) && !hit_d && !free_d) begin
            resp_evict_q     <= 1'b1;
            resp_evict_tag_q <= tag_mem_q[req_idx_q][victim_way_d];
          end else begin
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
          end
        end
        S_RESP: begin
          state_q          <= S_IDLE;
          ready_q          <= 1'b1;
          resp_hit_q       <= 1'b0;
          resp_way_q       <= '0;
          resp_evict_q     <= 1'b0;
          resp_evict_tag_q <= '0;
        end
        default: begin
          state_q <= S_FLUSH;
        end
      endcase
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_hit       = resp_hit_q;
  assign bus.resp_way       = resp_way_q;
  assign bus.resp_evict     = resp_evict_q;
  assign bus.resp_evict_tag = resp_evict_tag_q;
endmodule

// File: tb/tb_cache_tag_assoc.sv
// tb/tb_cache_tag_assoc.sv - self-checking bench for cache_tag_assoc
module tb_cache_tag_assoc;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 6;
  localparam int WAYS     = 2;
  localparam int SETS     = 64;
  localparam int TAG_W    = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_tag_assoc_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) bus ();

  cache_tag_assoc #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: each set is a list of ways {valid, tag} plus a replacement pointer.
  bit               m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  int               m_ptr   [SETS];

  logic [TAG_W-1:0] tag_pool [5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic void model_access(input logic [1:0] op, input logic [31:0] addr,
                                       output bit hit, output int way, output bit ev,
                                       output logic [TAG_W-1:0] evtag);
    int idx;
    int free_w;
    logic [TAG_W-1:0] t;
    idx    = int'(addr[7:2]);
    t      = addr[31:8];
    hit    = 1'b0;
    way    = 0;
    ev     = 1'b0;
    evtag  = '0;
    free_w = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && m_valid[idx][w] && m_tag[idx][w] == t) begin
        hit = 1'b1;
        way = w;
      end
      if (free_w < 0 && !m_valid[idx][w]) free_w = w;
    end
    if (op == 2'b01 && !hit) begin
      if (free_w >= 0) begin
        way = free_w;
      end else begin
        way        = m_ptr[idx];
        ev         = 1'b1;
        evtag      = m_tag[idx][way];
        m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
      end
      m_tag[idx][way]   = t;
      m_valid[idx][way] = 1'b1;
    end
    if (op == 2'b10 && hit) m_valid[idx][way] = 1'b0;
  endfunction

  // Called at a negedge where req_ready is low; follows a flush to its end.
  task automatic watch_flush(input string name, input bit expect_pulse);
    int n = 0;
    int pulses = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      if (bus.resp_valid === 1'b1) pulses++;
      n++;
      @(negedge clk);
    end
    chk({name, "_ready_low_cycles"}, 64'(n), 64'd64);
    chk({name, "_early_resp"}, 64'(pulses), 64'd0);
    chk({name, "_end_resp_valid"}, 64'(bus.resp_valid), 64'(expect_pulse));
    if (expect_pulse) begin
      chk({name, "_flush_hit"}, 64'(bus.resp_hit), 64'd0);
      chk({name, "_flush_way"}, 64'(bus.resp_way), 64'd0);
      chk({name, "_flush_evict"}, 64'(bus.resp_evict), 64'd0);
    end
    @(negedge clk);
    chk({name, "_pulse_one_cycle"}, 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input string name,
                        output bit o_hit, output int o_way, output bit o_ev,
                        output logic [TAG_W-1:0] o_evtag);
    bit e_hit;
    int e_way;
    bit e_ev;
    logic [TAG_W-1:0] e_evtag;
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_op    = op;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept_in_time"}, 64'(n < 200), 64'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request lines after acceptance; the engine must ignore them.
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_op    = 2'($urandom_range(0, 3));
    o_hit   = 1'b0;
    o_way   = 0;
    o_ev    = 1'b0;
    o_evtag = '0;
    if (op == 2'b11) begin
      model_clear();
      watch_flush(name, 1'b1);
      return;
    end
    model_access(op, addr, e_hit, e_way, e_ev, e_evtag);
    chk({name, "_busy_ready"}, 64'(bus.req_ready), 64'd0);
    chk({name, "_busy_resp"}, 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    chk({name, "_resp_valid"}, 64'(bus.resp_valid), 64'd1);
    chk({name, "_hit"}, 64'(bus.resp_hit), 64'(e_hit));
    chk({name, "_way"}, 64'(bus.resp_way), 64'(e_way));
    chk({name, "_evict"}, 64'(bus.resp_evict), 64'(e_ev));
    chk({name, "_evict_tag"}, 64'(bus.resp_evict_tag), 64'(e_evtag));
    o_hit   = bus.resp_hit;
    o_way   = int'(bus.resp_way);
    o_ev    = bus.resp_evict;
    o_evtag = bus.resp_evict_tag;
    @(negedge clk);
    chk({name, "_resp_done"}, 64'(bus.resp_valid), 64'd0);
    chk({name, "_ready_again"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_ready"}, 64'(bus.req_ready), 64'd0);
    chk({name, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({name, "_hit"}, 64'(bus.resp_hit), 64'd0);
    chk({name, "_way"}, 64'(bus.resp_way), 64'd0);
    chk({name, "_evict"}, 64'(bus.resp_evict), 64'd0);
    chk({name, "_evict_tag"}, 64'(bus.resp_evict_tag), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    int w;
    bit e;
    logic [TAG_W-1:0] et;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_op    = 2'b00;

    // 1. Reset, automatic flush, first lookup
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    rst_n = 1'b1;
    model_clear();
    watch_flush("s1_flush", 1'b0);
    do_req(2'b00, 32'h0000_1000, "s1_lookup", h, w, e, et);
    chk("s1_miss", 64'(h), 64'd0);

    // 2. Allocate, hit, allocate second way
    do_req(2'b01, 32'h0000_1000, "s2_alloc1", h, w, e, et);
    chk("s2_alloc1_const", {h, e, 32'(w)}, {1'b0, 1'b0, 32'd0});
    do_req(2'b00, 32'h0000_1000, "s2_look1", h, w, e, et);
    chk("s2_look1_const", {h, 32'(w)}, {1'b1, 32'd0});
    do_req(2'b01, 32'h0000_2000, "s2_alloc2", h, w, e, et);
    chk("s2_alloc2_const", {h, e, 32'(w)}, {1'b0, 1'b0, 32'd1});

    // 3. Round-robin eviction in a full set
    do_req(2'b01, 32'h0000_3000, "s3_evict1", h, w, e, et);
    chk("s3_evict1_const", {e, 32'(w), 24'(et)}, {1'b1, 32'd0, 24'h10});
    do_req(2'b01, 32'h0000_4000, "s3_evict2", h, w, e, et);
    chk("s3_evict2_const", {e, 32'(w), 24'(et)}, {1'b1, 32'd1, 24'h20});
    do_req(2'b00, 32'h0000_1000, "s3_gone", h, w, e, et);
    chk("s3_gone_const", 64'(h), 64'd0);

    // 4. Invalidate, then invalid-first fill
    do_req(2'b10, 32'h0000_4000, "s4_inval", h, w, e, et);
    chk("s4_inval_const", {h, 32'(w)}, {1'b1, 32'd1});
    do_req(2'b00, 32'h0000_4000, "s4_look", h, w, e, et);
    chk("s4_look_const", 64'(h), 64'd0);
    do_req(2'b01, 32'h0000_5000, "s4_fill", h, w, e, et);
    chk("s4_fill_const", {e, 32'(w)}, {1'b0, 32'd1});

    // 5. Flush op
    do_req(2'b11, 32'h0, "s5_flush", h, w, e, et);
    do_req(2'b00, 32'h0000_3000, "s5_look3", h, w, e, et);
    chk("s5_look3_const", 64'(h), 64'd0);
    do_req(2'b00, 32'h0000_5000, "s5_look5", h, w, e, et);
    chk("s5_look5_const", 64'(h), 64'd0);

    // 6. Reset during LOOKUP aborts the request
    do_req(2'b01, 32'h0000_1000, "s6_alloc", h, w, e, et);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_2000;
    bus.req_op    = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("s6_abort");
    rst_n = 1'b1;
    model_clear();
    watch_flush("s6_flush", 1'b0);
    do_req(2'b00, 32'h0000_1000, "s6_look1", h, w, e, et);
    chk("s6_look1_const", 64'(h), 64'd0);
    do_req(2'b00, 32'h0000_2000, "s6_look2", h, w, e, et);
    chk("s6_look2_const", 64'(h), 64'd0);

    // Randomised traffic against the model; a small tag pool and a few
    // favoured sets (including the last one) keep hits and evictions frequent.
    for (int i = 0; i < 5; i++) tag_pool[i] = 24'($urandom);
    for (int i = 0; i < 300; i++) begin
      int r;
      int idx;
      logic [1:0] op;
      logic [31:0] a;
      r = int'($urandom_range(0, 99));
      op = (r < 45) ? 2'b01 : (r < 80) ? 2'b00 : (r < 97) ? 2'b10 : 2'b11;
      case ($urandom_range(0, 3))
        0: idx = 0;
        1: idx = 1;
        2: idx = SETS - 1;
        default: idx = int'($urandom_range(0, SETS - 1));
      endcase
      a = {tag_pool[$urandom_range(0, 4)], 6'(idx), 2'($urandom_range(0, 3))};
      do_req(op, a, "rnd", h, w, e, et);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
